// File: rtl/mem_ctrler_if.sv
// Requester-side bus of the memory controller: instruction-fetcher line fills
// and load/store unit accesses, each with a valid/ready handshake.
interface mem_ctrler_if #(
  parameter int CACHE_LINE_SIZE = 16
);
  logic                         valid_from_inst_fetcher;
  logic [31:0]                  addr_from_inst_fetcher;
  logic                         ready_to_inst_fetcher;
  logic [8*CACHE_LINE_SIZE-1:0] cache_line_to_inst_fetcher;

  logic                         valid_from_lsu;
  logic                         wr_from_lsu;
  logic [1:0]                   len_from_lsu;
  logic [31:0]                  addr_from_lsu;
  logic [31:0]                  data_from_lsu;
  logic                         ready_to_lsu;
  logic [31:0]                  data_to_lsu;

  modport slave (
    input  valid_from_inst_fetcher, addr_from_inst_fetcher,
    output ready_to_inst_fetcher, cache_line_to_inst_fetcher,
    input  valid_from_lsu, wr_from_lsu, len_from_lsu, addr_from_lsu, data_from_lsu,
    output ready_to_lsu, data_to_lsu
  );

  modport master (
    output valid_from_inst_fetcher, addr_from_inst_fetcher,
    input  ready_to_inst_fetcher, cache_line_to_inst_fetcher,
    output valid_from_lsu, wr_from_lsu, len_from_lsu, addr_from_lsu, data_from_lsu,
    input  ready_to_lsu, data_to_lsu
  );
endinterface

// File: rtl/mem_ctrler.sv
// Owner of the byte-wide unified RAM port: serialises fetcher line fills and
// LSU loads/stores into per-byte RAM cycles, little-endian.
module mem_ctrler #(
  parameter int          CACHE_LINE_SIZE = 16,
  parameter logic [31:0] IO_BASE         = 32'h30000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        io_buffer_full,
  mem_ctrler_if.slave bus,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  localparam int LINE_W = 8 * CACHE_LINE_SIZE;
  localparam int CNT_W  = $clog2(CACHE_LINE_SIZE + 2);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t            state_q, state_d;
  logic              src_lsu_q, src_lsu_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [31:0]       base_q, base_d;
  logic [31:0]       st_data_q, st_data_d;
  logic [LINE_W-1:0] buf_q, buf_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [31:0]       lsu_data_q, lsu_data_d;
  logic              ready_if_q, ready_if_d;
  logic              ready_lsu_q, ready_lsu_d;
  logic [31:0]       mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;

  logic [31:0]       cur_addr;
  logic [7:0]        st_byte;
  logic              stall;
  logic              first_stall;
  logic [CNT_W-1:0]  lsu_n;

  assign cur_addr    = base_q + 32'(cnt_q);
  assign stall       = io_buffer_full && (cur_addr >= IO_BASE);
  assign first_stall = io_buffer_full && (bus.addr_from_lsu >= IO_BASE);

  always_comb begin
    case (bus.len_from_lsu)
      2'd0:    lsu_n = CNT_W'(1);
      2'd1:    lsu_n = CNT_W'(2);
      default: lsu_n = CNT_W'(4);
    endcase
  end

  always_comb begin
    case (cnt_q[1:0])
      2'd0: st_byte = st_data_q[7:0];
      2'd1: st_byte = st_data_q[15:8];
      2'd2: st_byte = st_data_q[23:16];
      2'd3: st_byte = st_data_q[31:24];
    endcase
  end

  // Reads run two bytes behind the address: slot k is captured when cnt reaches k+2.
  always_comb begin
    state_d     = state_q;
    src_lsu_d   = src_lsu_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    base_d      = base_q;
    st_data_d   = st_data_q;
    buf_d       = buf_q;
    line_d      = line_q;
    lsu_data_d  = lsu_data_q;
    ready_if_d  = 1'b0;
    ready_lsu_d = 1'b0;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!ready_if_q && !ready_lsu_q) begin
          if (bus.valid_from_lsu) begin
            src_lsu_d = 1'b1;
            base_d    = bus.addr_from_lsu;
            st_data_d = bus.data_from_lsu;
            n_d       = lsu_n;
            if (bus.wr_from_lsu) begin
              state_d = WRITE;
              cnt_d   = '0;
              if (!first_stall) begin
                mem_a_d    = bus.addr_from_lsu;
                mem_dout_d = bus.data_from_lsu[7:0];
                mem_wr_d   = 1'b1;
                cnt_d      = CNT_W'(1);
              end
            end else begin
              state_d = READ;
              mem_a_d = bus.addr_from_lsu;
              cnt_d   = CNT_W'(1);
            end
          end else if (bus.valid_from_inst_fetcher) begin
            src_lsu_d = 1'b0;
            base_d    = bus.addr_from_inst_fetcher;
            n_d       = CNT_W'(CACHE_LINE_SIZE);
            state_d   = READ;
            mem_a_d   = bus.addr_from_inst_fetcher;
            cnt_d     = CNT_W'(1);
          end
        end
      end

      READ: begin
        if (cnt_q < n_q)
          mem_a_d = cur_addr;
        for (int i = 0; i < CACHE_LINE_SIZE; i++) begin
          if (cnt_q == CNT_W'(i + 2))
            buf_d[i*8 +: 8] = mem_din;
        end
        if (cnt_q == n_q + CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (src_lsu_q) begin
            ready_lsu_d = 1'b1;
            if (n_q == CNT_W'(1))
              lsu_data_d = {24'd0, buf_d[7:0]};
            else if (n_q == CNT_W'(2))
              lsu_data_d = {16'd0, buf_d[15:0]};
            else
              lsu_data_d = buf_d[31:0];
          end else begin
            ready_if_d = 1'b1;
            line_d     = buf_d;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WRITE: begin
        if (cnt_q == n_q) begin
          state_d     = IDLE;
          cnt_d       = '0;
          ready_lsu_d = 1'b1;
        end else if (!stall) begin
          mem_a_d    = cur_addr;
          mem_dout_d = st_byte;
          mem_wr_d   = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // rdy low freezes every register; the write strobe is masked separately below.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      src_lsu_q   <= 1'b0;
      cnt_q       <= '0;
      n_q         <= '0;
      base_q      <= '0;
      st_data_q   <= '0;
      buf_q       <= '0;
      line_q      <= '0;
      lsu_data_q  <= '0;
      ready_if_q  <= 1'b0;
      ready_lsu_q <= 1'b0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
    end else if (rdy) begin
      state_q     <= state_d;
      src_lsu_q   <= src_lsu_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      base_q      <= base_d;
      st_data_q   <= st_data_d;
      buf_q       <= buf_d;
      line_q      <= line_d;
      lsu_data_q  <= lsu_data_d;
      ready_if_q  <= ready_if_d;
      ready_lsu_q <= ready_lsu_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q & rdy;

  assign bus.ready_to_inst_fetcher      = ready_if_q;
  assign bus.cache_line_to_inst_fetcher = line_q;
  assign bus.ready_to_lsu               = ready_lsu_q;
  assign bus.data_to_lsu                = lsu_data_q;

endmodule

// File: tb/tb_mem_ctrler.sv
// Directed bench for mem_ctrler: fills, loads, stores, priority, I/O stall,
// global-enable freeze and asynchronous reset mid-transfer.
module tb_mem_ctrler;

  localparam int LINE = 16;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  logic [7:0]  ram [0:4095];
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [7:0]  pre_data;
  int          wr_cnt = 0;
  int          io_writes = 0;
  logic [31:0] wr_addr_log [0:63];
  logic [7:0]  wr_data_log [0:63];
  logic [7:0]  io_last;

  int tests = 0;
  int fails = 0;

  mem_ctrler_if #(.CACHE_LINE_SIZE(LINE)) bus ();

  mem_ctrler #(.CACHE_LINE_SIZE(LINE), .IO_BASE(32'h30000)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .io_buffer_full (io_buffer_full),
    .bus            (bus.slave),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte RAM sharing the global enable: registered read, write on mem_wr.
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    if (rdy) begin
      mem_din <= ram[mem_a[11:0]];
      if (mem_wr) begin
        if (wr_cnt < 64) begin
          wr_addr_log[wr_cnt] <= mem_a;
          wr_data_log[wr_cnt] <= mem_dout;
        end
        wr_cnt <= wr_cnt + 1;
        if (mem_a >= 32'h30000) begin
          io_writes <= io_writes + 1;
          io_last   <= mem_dout;
        end else begin
          ram[mem_a[11:0]] <= mem_dout;
        end
      end
    end
  end

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic start_lsu(input logic wr, input logic [1:0] len, input logic [31:0] a, input logic [31:0] d);
    bus.wr_from_lsu    = wr;
    bus.len_from_lsu   = len;
    bus.addr_from_lsu  = a;
    bus.data_from_lsu  = d;
    bus.valid_from_lsu = 1'b1;
  endtask

  // Counts negedges (one per clock) until the selected ready is seen, bounded.
  task automatic wait_ready(input bit lsu, output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end while (!(lsu ? bus.ready_to_lsu : bus.ready_to_inst_fetcher) && edges < 100);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++; if (bus.ready_to_inst_fetcher !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready_if: got %b expected 0", bus.ready_to_inst_fetcher); end
    tests++; if (bus.ready_to_lsu !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready_lsu: got %b expected 0", bus.ready_to_lsu); end
    tests++; if (bus.cache_line_to_inst_fetcher !== '0) begin fails++; $display("[TB] FAIL reset_line: got %h expected 0", bus.cache_line_to_inst_fetcher); end
    tests++; if (bus.data_to_lsu !== 32'h0) begin fails++; $display("[TB] FAIL reset_data: got %h expected 0", bus.data_to_lsu); end
    tests++; if (mem_wr !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_wr: got %b expected 0", mem_wr); end
    tests++; if (mem_a !== 32'h0) begin fails++; $display("[TB] FAIL reset_mem_a: got %h expected 0", mem_a); end
    tests++; if (mem_dout !== 8'h0) begin fails++; $display("[TB] FAIL reset_mem_dout: got %h expected 0", mem_dout); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill();
    int e;
    for (int i = 0; i < 16; i++) poke(12'h100 + 12'(i), 8'(i));
    @(negedge clk);
    bus.addr_from_inst_fetcher  = 32'h100;
    bus.valid_from_inst_fetcher = 1'b1;
    wait_ready(1'b0, e);
    bus.valid_from_inst_fetcher = 1'b0;
    // acceptance edge plus 17 more
    tests++; if (e !== 18) begin fails++; $display("[TB] FAIL fill_latency: got %0d clocks expected 18", e); end
    tests++; if (bus.cache_line_to_inst_fetcher !== 128'h0F0E0D0C0B0A09080706050403020100) begin fails++; $display("[TB] FAIL fill_line: got %h expected 0f0e..0100", bus.cache_line_to_inst_fetcher); end
    @(posedge clk); @(negedge clk);
    tests++; if (bus.ready_to_inst_fetcher !== 1'b0) begin fails++; $display("[TB] FAIL fill_pulse: got %b expected 0", bus.ready_to_inst_fetcher); end
    tests++; if (bus.cache_line_to_inst_fetcher !== 128'h0F0E0D0C0B0A09080706050403020100) begin fails++; $display("[TB] FAIL fill_hold: got %h", bus.cache_line_to_inst_fetcher); end
  endtask

  task automatic test_load();
    int e;
    poke(12'h200, 8'h11); poke(12'h201, 8'h22); poke(12'h202, 8'h33); poke(12'h203, 8'h44);
    @(negedge clk);
    start_lsu(1'b0, 2'd2, 32'h200, 32'h0);
    wait_ready(1'b1, e);
    bus.valid_from_lsu = 1'b0;
    tests++; if (e !== 6) begin fails++; $display("[TB] FAIL load4_latency: got %0d expected 6", e); end
    tests++; if (bus.data_to_lsu !== 32'h44332211) begin fails++; $display("[TB] FAIL load4_data: got %h expected 44332211", bus.data_to_lsu); end
    @(posedge clk); @(negedge clk);
    tests++; if (bus.ready_to_lsu !== 1'b0) begin fails++; $display("[TB] FAIL load4_pulse: got %b expected 0", bus.ready_to_lsu); end
    start_lsu(1'b0, 2'd0, 32'h203, 32'h0);
    wait_ready(1'b1, e);
    bus.valid_from_lsu = 1'b0;
    tests++; if (e !== 3) begin fails++; $display("[TB] FAIL load1_latency: got %0d expected 3", e); end
    tests++; if (bus.data_to_lsu !== 32'h00000044) begin fails++; $display("[TB] FAIL load1_data: got %h expected 00000044", bus.data_to_lsu); end
    @(posedge clk); @(negedge clk);
    start_lsu(1'b0, 2'd1, 32'h201, 32'h0);
    wait_ready(1'b1, e);
    bus.valid_from_lsu = 1'b0;
    tests++; if (e !== 4) begin fails++; $display("[TB] FAIL load2_latency: got %0d expected 4", e); end
    tests++; if (bus.data_to_lsu !== 32'h00003322) begin fails++; $display("[TB] FAIL load2_data: got %h expected 00003322", bus.data_to_lsu); end
    tests++; if (bus.cache_line_to_inst_fetcher !== 128'h0F0E0D0C0B0A09080706050403020100) begin fails++; $display("[TB] FAIL line_hold_on_load: got %h", bus.cache_line_to_inst_fetcher); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_store();
    int e;
    int w0;
    poke(12'h300, 8'hAA); poke(12'h301, 8'hBB); poke(12'h302, 8'hCC);
    @(negedge clk);
    w0 = wr_cnt;
    start_lsu(1'b1, 2'd1, 32'h300, 32'hDEADBEEF);
    wait_ready(1'b1, e);
    bus.valid_from_lsu = 1'b0;
    tests++; if (e !== 3) begin fails++; $display("[TB] FAIL store2_latency: got %0d expected 3", e); end
    tests++; if (wr_cnt - w0 !== 2) begin fails++; $display("[TB] FAIL store2_count: got %0d writes expected 2", wr_cnt - w0); end
    tests++; if (wr_addr_log[w0] !== 32'h300 || wr_data_log[w0] !== 8'hEF) begin fails++; $display("[TB] FAIL store2_byte0: got %h@%h expected ef@300", wr_data_log[w0], wr_addr_log[w0]); end
    tests++; if (wr_addr_log[w0+1] !== 32'h301 || wr_data_log[w0+1] !== 8'hBE) begin fails++; $display("[TB] FAIL store2_byte1: got %h@%h expected be@301", wr_data_log[w0+1], wr_addr_log[w0+1]); end
    tests++; if (ram[12'h302] !== 8'hCC) begin fails++; $display("[TB] FAIL store2_untouched: got %h expected cc", ram[12'h302]); end
    @(posedge clk); @(negedge clk);
    start_lsu(1'b1, 2'd2, 32'h310, 32'h12345678);
    wait_ready(1'b1, e);
    bus.valid_from_lsu = 1'b0;
    tests++; if (e !== 5) begin fails++; $display("[TB] FAIL store4_latency: got %0d expected 5", e); end
    @(posedge clk); @(negedge clk);
    start_lsu(1'b0, 2'd2, 32'h310, 32'h0);
    wait_ready(1'b1, e);
    bus.valid_from_lsu = 1'b0;
    tests++; if (bus.data_to_lsu !== 32'h12345678) begin fails++; $display("[TB] FAIL store4_readback: got %h expected 12345678", bus.data_to_lsu); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_priority();
    int e = 0;
    int lsu_at = 0;
    int if_at = 0;
    int lsu_pulses = 0;
    bus.addr_from_inst_fetcher  = 32'h100;
    bus.valid_from_inst_fetcher = 1'b1;
    start_lsu(1'b0, 2'd2, 32'h200, 32'h0);
    while (if_at == 0 && e < 100) begin
      @(posedge clk); @(negedge clk); e++;
      if (bus.ready_to_lsu) begin
        lsu_pulses++;
        if (lsu_at == 0) lsu_at = e;
        bus.valid_from_lsu = 1'b0;
      end
      if (bus.ready_to_inst_fetcher) begin
        if_at = e;
        bus.valid_from_inst_fetcher = 1'b0;
      end
    end
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      if (bus.ready_to_lsu) lsu_pulses++;
    end
    tests++; if (lsu_at !== 6) begin fails++; $display("[TB] FAIL prio_lsu_first: got %0d expected 6", lsu_at); end
    // load ready after clock 6, ready cycle blocks clock 7, fetch accepted at clock 8
    tests++; if (if_at !== 25) begin fails++; $display("[TB] FAIL prio_fetch_after: got %0d expected 25", if_at); end
    tests++; if (lsu_pulses !== 1) begin fails++; $display("[TB] FAIL prio_no_dup: got %0d pulses expected 1", lsu_pulses); end
    tests++; if (bus.data_to_lsu !== 32'h44332211) begin fails++; $display("[TB] FAIL prio_data: got %h expected 44332211", bus.data_to_lsu); end
    tests++; if (bus.cache_line_to_inst_fetcher !== 128'h0F0E0D0C0B0A09080706050403020100) begin fails++; $display("[TB] FAIL prio_line: got %h", bus.cache_line_to_inst_fetcher); end
  endtask

  task automatic test_io_stall();
    int e;
    int i0;
    int c0;
    i0 = io_writes;
    c0 = wr_cnt;
    io_buffer_full = 1'b1;
    start_lsu(1'b1, 2'd0, 32'h30000, 32'h00000041);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      tests++; if (mem_wr !== 1'b0) begin fails++; $display("[TB] FAIL io_stall_wr cycle %0d: got %b expected 0", i, mem_wr); end
    end
    tests++; if (io_writes - i0 !== 0 || bus.ready_to_lsu !== 1'b0) begin fails++; $display("[TB] FAIL io_stall_hold: got %0d writes ready %b expected 0 writes ready 0", io_writes - i0, bus.ready_to_lsu); end
    io_buffer_full = 1'b0;
    wait_ready(1'b1, e);
    bus.valid_from_lsu = 1'b0;
    tests++; if (e !== 2) begin fails++; $display("[TB] FAIL io_release_latency: got %0d expected 2", e); end
    tests++; if (io_writes - i0 !== 1 || wr_cnt - c0 !== 1) begin fails++; $display("[TB] FAIL io_single_write: got %0d io %0d total expected 1 1", io_writes - i0, wr_cnt - c0); end
    tests++; if (io_last !== 8'h41) begin fails++; $display("[TB] FAIL io_data: got %h expected 41", io_last); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_freeze_and_reset();
    int e;
    int pulses = 0;
    for (int i = 0; i < 16; i++) poke(12'h100 + 12'(i), 8'hA0 + 8'(i));
    @(negedge clk);
    bus.addr_from_inst_fetcher  = 32'h100;
    bus.valid_from_inst_fetcher = 1'b1;
    repeat (6) begin @(posedge clk); @(negedge clk); end
    rdy = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    tests++; if (mem_a !== 32'h105) begin fails++; $display("[TB] FAIL freeze_hold_addr: got %h expected 105", mem_a); end
    rdy = 1'b1;
    wait_ready(1'b0, e);
    bus.valid_from_inst_fetcher = 1'b0;
    tests++; if (9 + e !== 21) begin fails++; $display("[TB] FAIL freeze_latency: got %0d expected 21", 9 + e); end
    tests++; if (bus.cache_line_to_inst_fetcher !== 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0) begin fails++; $display("[TB] FAIL freeze_line: got %h expected afae..a1a0", bus.cache_line_to_inst_fetcher); end
    @(posedge clk); @(negedge clk);

    start_lsu(1'b1, 2'd2, 32'h340, 32'hCAFEF00D);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    tests++; if (mem_wr !== 1'b1) begin fails++; $display("[TB] FAIL store_in_progress: got %b expected 1", mem_wr); end
    rst = 1'b0;
    #1;
    tests++; if (mem_wr !== 1'b0 || mem_a !== 32'h0 || mem_dout !== 8'h0) begin fails++; $display("[TB] FAIL rst_mem_port: got wr %b a %h d %h expected all 0", mem_wr, mem_a, mem_dout); end
    tests++; if (bus.ready_to_lsu !== 1'b0 || bus.ready_to_inst_fetcher !== 1'b0) begin fails++; $display("[TB] FAIL rst_ready: got %b %b expected 0 0", bus.ready_to_lsu, bus.ready_to_inst_fetcher); end
    tests++; if (bus.data_to_lsu !== 32'h0 || bus.cache_line_to_inst_fetcher !== '0) begin fails++; $display("[TB] FAIL rst_data: got %h %h expected 0", bus.data_to_lsu, bus.cache_line_to_inst_fetcher); end
    bus.valid_from_lsu = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      if (bus.ready_to_lsu) pulses++;
    end
    tests++; if (pulses !== 0) begin fails++; $display("[TB] FAIL rst_no_pulse: got %0d expected 0", pulses); end
    start_lsu(1'b0, 2'd0, 32'h200, 32'h0);
    wait_ready(1'b1, e);
    bus.valid_from_lsu = 1'b0;
    tests++; if (e !== 3 || bus.data_to_lsu !== 32'h00000011) begin fails++; $display("[TB] FAIL rst_then_idle: got %0d clocks data %h expected 3 00000011", e, bus.data_to_lsu); end
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    rst            = 1'b0;
    rdy            = 1'b1;
    io_buffer_full = 1'b0;
    pre_we         = 1'b0;
    pre_addr       = '0;
    pre_data       = '0;
    bus.valid_from_inst_fetcher = 1'b0;
    bus.addr_from_inst_fetcher  = '0;
    bus.valid_from_lsu          = 1'b0;
    bus.wr_from_lsu             = 1'b0;
    bus.len_from_lsu            = 2'd0;
    bus.addr_from_lsu           = '0;
    bus.data_from_lsu           = '0;

    test_reset();
    test_fill();
    test_load();
    test_store();
    test_priority();
    test_io_stall();
    test_freeze_and_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
